// File: rtl/sm3_pkg.sv
// Shared constants and the 3:2 carry-save helper for the SM3 multi-operand adder.
package sm3_pkg;

    localparam int unsigned SM3_WORD_W = 32;
    localparam int unsigned MAX_W      = 64;

    // SM3 initial hash value; index 0 is the first word.
    localparam logic [7:0][31:0] SM3_IV = {
        32'hB0FB0E4E, 32'hE38DEE4D, 32'h163138AA, 32'hA96F30BC,
        32'hDA8A0600, 32'h172442D7, 32'h4914B2B9, 32'h7380166F
    };

    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic [MAX_W-1:0] carry;
    } csa_pair_t;

    function automatic csa_pair_t csa3(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input logic [MAX_W-1:0] c);
        csa_pair_t r;
        r.sum   = a ^ b ^ c;
        r.carry = ((a & b) | (a & c) | (b & c)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/sm3_madd_pipe_if.sv
// Operand-bundle / result handshake bundle for sm3_madd_pipe.
interface sm3_madd_pipe_if
    import sm3_pkg::*;
#(
    parameter int unsigned WIDTH = SM3_WORD_W,
    parameter int unsigned N_OPS = 4
) ();

    logic                   in_valid;
    logic                   in_ready;
    logic [N_OPS*WIDTH-1:0] in_ops;
    logic [N_OPS-1:0]       in_mask;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_sum;

    modport master (
        output in_valid, in_ops, in_mask, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_ops, in_mask, out_ready,
        output in_ready, out_valid, out_sum
    );

endinterface

// File: rtl/sm3_csa_tree.sv
// Combinational 3:2 carry-save reduction of N_OPS words down to a (sum, carry) pair.
module sm3_csa_tree
    import sm3_pkg::*;
#(
    parameter int unsigned WIDTH = SM3_WORD_W,
    parameter int unsigned N_OPS = 4
) (
    input  logic [N_OPS*WIDTH-1:0] ops,
    output logic [WIDTH-1:0]       sum,
    output logic [WIDTH-1:0]       carry
);

    // 8 -> 6 -> 4 -> 3 -> 2: four levels cover N_OPS <= 8; once two words remain, levels pass through.
    localparam int NLvl = 4;

    logic [WIDTH-1:0] cur [N_OPS];
    logic [WIDTH-1:0] nxt [N_OPS];
    csa_pair_t        pair;
    int               cnt;
    int               grp;
    logic             unused_pair;

    always_comb begin
        pair = '0;
        cnt  = N_OPS;
        grp  = 0;
        for (int k = 0; k < N_OPS; k++) begin
            cur[k] = ops[k*WIDTH +: WIDTH];
            nxt[k] = '0;
        end
        for (int l = 0; l < NLvl; l++) begin
            grp = cnt / 3;
            for (int k = 0; k < N_OPS; k++) begin
                nxt[k] = '0;
            end
            for (int g = 0; g < N_OPS / 3; g++) begin
                if (g < grp) begin
                    pair = csa3(MAX_W'(cur[3*g]), MAX_W'(cur[3*g+1]), MAX_W'(cur[3*g+2]));
                    nxt[2*g]   = pair.sum[WIDTH-1:0];
                    nxt[2*g+1] = pair.carry[WIDTH-1:0];
                end
            end
            // Words left over from the last incomplete group of three ride to the next level.
            for (int r = 0; r < 2; r++) begin
                if (r < cnt % 3) begin
                    nxt[2*grp + r] = cur[3*grp + r];
                end
            end
            cur = nxt;
            cnt = 2 * grp + cnt % 3;
        end
        sum   = cur[0];
        carry = cur[1];
    end

    // Carries beyond WIDTH-1 are discarded by design.
    assign unused_pair = ^pair;

endmodule

// File: rtl/sm3_madd_pipe.sv
// Two-stage masked multi-operand adder mod 2^WIDTH: CSA reduction, then carry-propagate add.
module sm3_madd_pipe
    import sm3_pkg::*;
#(
    parameter int unsigned WIDTH = SM3_WORD_W,
    parameter int unsigned N_OPS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    sm3_madd_pipe_if.slave bus
);

    logic [N_OPS*WIDTH-1:0] masked_ops;
    logic [WIDTH-1:0]       tree_sum;
    logic [WIDTH-1:0]       tree_carry;
    logic [WIDTH-1:0]       s1_sum;
    logic [WIDTH-1:0]       s1_carry;
    logic                   s1_valid;
    logic [WIDTH-1:0]       out_sum;
    logic                   out_valid;
    logic                   s1_adv;
    logic                   s2_adv;

    always_comb begin
        masked_ops = '0;
        for (int k = 0; k < N_OPS; k++) begin
            masked_ops[k*WIDTH +: WIDTH] = bus.in_mask[k] ? bus.in_ops[k*WIDTH +: WIDTH] : '0;
        end
    end

    sm3_csa_tree #(
        .WIDTH (WIDTH),
        .N_OPS (N_OPS)
    ) u_tree (
        .ops   (masked_ops),
        .sum   (tree_sum),
        .carry (tree_carry)
    );

    // Ready ripples back combinationally so a full pipe can drain and refill in one cycle.
    assign s2_adv       = !out_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
            end
        end
    end

    // Data registers ignore flush: their contents are meaningless once valid is cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum   <= '0;
            s1_carry <= '0;
            out_sum  <= '0;
        end else begin
            if (s1_adv && bus.in_valid) begin
                s1_sum   <= tree_sum;
                s1_carry <= tree_carry;
            end
            if (s2_adv && s1_valid) begin
                out_sum <= s1_sum + s1_carry;
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum;

endmodule

// File: tb/tb_sm3_madd_pipe.sv
// Randomised and directed checks of sm3_madd_pipe against a plain-arithmetic reference model.
module tb_sm3_madd_pipe;
    import sm3_pkg::*;

    localparam int unsigned NCFG = 5;
    localparam int unsigned CFG_W [NCFG] = '{8, 32, 8, 32, 8};
    localparam int unsigned CFG_N [NCFG] = '{2, 3, 4, 8, 8};

    logic clk;
    logic rst_n;
    logic rst_n_aux;
    logic flush;
    logic flush_aux;
    logic [NCFG-1:0] aux_done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [63:0] exp_q [$];

    sm3_madd_pipe_if #(.WIDTH(32), .N_OPS(4)) bus ();

    sm3_madd_pipe #(
        .WIDTH (32),
        .N_OPS (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Sum of the enabled w-bit slots of ops, reduced mod 2^w.
    function automatic logic [63:0] ref_sum(input logic [511:0] ops, input logic [7:0] mask,
                                            input int unsigned w, input int unsigned n);
        logic [63:0]  wmask;
        logic [63:0]  total;
        logic [511:0] sh;
        wmask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        total = '0;
        for (int k = 0; k < n; k++) begin
            sh = ops >> (k * w);
            if (mask[k]) total = total + (sh[63:0] & wmask);
        end
        return total & wmask;
    endfunction

    // Scoreboard for the main instance: push on accept, pop on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check_eq("unexpected_out", 64'(exp_q.size()), 64'd1);
                else check_eq("stream_sum", 64'(bus.out_sum), exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            else if (bus.in_valid && bus.in_ready)
                exp_q.push_back(ref_sum(512'(bus.in_ops), 8'(bus.in_mask), 32, 4));
        end
    end

    // Expects an empty pipe, out_ready high, and to be entered #1 after a rising edge.
    task automatic single(input string tag, input logic [127:0] ops, input logic [3:0] mask,
                          input logic [31:0] exp);
        bus.in_ops   = ops;
        bus.in_mask  = mask;
        bus.in_valid = 1'b1;
        #1 check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        check_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check_eq({tag, "_sum"}, 64'(bus.out_sum), 64'(exp));
        @(posedge clk); #1;
    endtask

    task automatic rand_bundle();
        bus.in_ops  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_mask = 4'($urandom);
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_aux
        localparam int unsigned W = CFG_W[g];
        localparam int unsigned N = CFG_N[g];

        sm3_madd_pipe_if #(.WIDTH(W), .N_OPS(N)) abus ();

        sm3_madd_pipe #(
            .WIDTH (W),
            .N_OPS (N)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n_aux),
            .flush (flush_aux),
            .bus   (abus)
        );

        logic [63:0] q [$];
        int unsigned got = 0;
        bit          done = 1'b0;

        assign aux_done[g] = done;

        always @(negedge clk) begin
            if (rst_n_aux) begin
                if (abus.out_valid && abus.out_ready) begin
                    if (q.size() == 0) check_eq("aux_unexpected", 64'(q.size()), 64'd1);
                    else begin
                        check_eq("aux_sum", 64'(abus.out_sum), q.pop_front());
                        got++;
                    end
                end
                if (abus.in_valid && abus.in_ready)
                    q.push_back(ref_sum(512'(abus.in_ops), 8'(abus.in_mask), W, N));
            end
        end

        initial begin
            abus.in_valid  = 1'b0;
            abus.in_ops    = '0;
            abus.in_mask   = '0;
            abus.out_ready = 1'b1;
            wait (rst_n_aux);
            @(posedge clk); #1;
            for (int i = 0; i < 100; i++) begin
                abus.in_valid = 1'b1;
                for (int k = 0; k < N; k++) abus.in_ops[k*W +: W] = W'($urandom);
                abus.in_mask = N'($urandom);
                check_eq("aux_in_ready", 64'(abus.in_ready), 64'd1);
                @(posedge clk); #1;
                if (i >= 1) check_eq("aux_tput", 64'(abus.out_valid), 64'd1);
            end
            abus.in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1 check_eq("aux_count", 64'(got), 64'd100);
            done = 1'b1;
        end
    end

    initial begin
        logic [127:0] ops_a;
        logic [127:0] ops_b;
        logic [127:0] ops_c;
        logic [127:0] ops_iv;
        logic [31:0]  exp_a;
        logic [31:0]  exp_b;
        logic [31:0]  exp_c;

        rst_n         = 1'b0;
        rst_n_aux     = 1'b0;
        flush         = 1'b0;
        flush_aux     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ops    = '0;
        bus.in_mask   = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_sum", 64'(bus.out_sum), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rst_n_aux = 1'b1;
        #1 check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        ops_iv = {32'hDEADBEEF, SM3_IV[2], SM3_IV[1], SM3_IV[0]};
        single("wrap", {32'h0, 32'h0, 32'h1, 32'hFFFFFFFF}, 4'b1111, 32'h00000000);
        single("iv_m0111", ops_iv, 4'b0111, 32'hD3B90BFF);
        single("iv_m0000", ops_iv, 4'b0000, 32'h00000000);
        single("iv_m1111", ops_iv, 4'b1111, 32'hB266CAEE);
        single("iv_m1001", ops_iv, 4'b1001, 32'h522DD55E);

        // Backpressure: two acceptances fill the pipe, the third waits for the first to drain.
        ops_a = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        ops_b = {$urandom, $urandom, $urandom, $urandom};
        ops_c = {$urandom, $urandom, $urandom, $urandom};
        exp_a = 32'hAAAAAAAA;
        exp_b = ref_sum(512'(ops_b), 8'hF, 32, 4)[31:0];
        exp_c = ref_sum(512'(ops_c), 8'h7, 32, 4)[31:0];
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mask   = 4'b1111;
        bus.in_ops    = ops_a;
        @(posedge clk); #1;
        bus.in_ops = ops_b;
        @(posedge clk); #1;
        bus.in_ops  = ops_c;
        bus.in_mask = 4'b0111;
        check_eq("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check_eq("bp_hold_sum", 64'(bus.out_sum), 64'(exp_a));
            check_eq("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1 check_eq("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("bp_second", 64'(bus.out_sum), 64'(exp_b));
        @(posedge clk); #1;
        check_eq("bp_third", 64'(bus.out_sum), 64'(exp_c));
        check_eq("bp_third_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        check_eq("bp_empty", 64'(bus.out_valid), 64'd0);

        // Flush with two results in flight; the bundle offered during flush must vanish too.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        rand_bundle();
        @(posedge clk); #1;
        rand_bundle();
        @(posedge clk); #1;
        check_eq("fl_full", 64'(bus.out_valid), 64'd1);
        flush = 1'b1;
        rand_bundle();
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("fl_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("fl_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        check_eq("fl_no_stale", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        single("fl_after", ops_b, 4'b1010, ref_sum(512'(ops_b), 8'hA, 32, 4)[31:0]);

        // Continuous stream: one result per cycle.
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1;
            rand_bundle();
            @(posedge clk); #1;
            if (i >= 1) check_eq("tput_valid", 64'(bus.out_valid), 64'd1);
        end

        // Random valid and backpressure; scoreboard checks order and values.
        for (int i = 0; i < 150; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.out_ready = 1'($urandom);
            rand_bundle();
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-stream.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            rand_bundle();
            @(posedge clk); #1;
        end
        #2;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        #1 check_eq("ar_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("ar_out_sum", 64'(bus.out_sum), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("ar_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("ar_no_stale", 64'(bus.out_valid), 64'd0);
        end
        single("ar_after", ops_c, 4'b1101, ref_sum(512'(ops_c), 8'hD, 32, 4)[31:0]);

        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);

        for (int i = 0; i < 2000 && aux_done != {NCFG{1'b1}}; i++) @(posedge clk);
        #1 check_eq("aux_done", 64'(aux_done), 64'({NCFG{1'b1}}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sm3_madd_pipe.md
# sm3_madd_pipe

Pipelined, parametrised multi-operand modular adder for the SM3 compression datapath; next generation of the fixed 3-input 32-bit CSA adder. It sums up to N_OPS words modulo 2^WIDTH through a carry-save reduction tree and a final carry-propagate adder, with a per-operand enable mask. It sits between the message-expansion/register file and the round logic and decouples them with a valid/ready handshake at one result per cycle.

## Interface
- WIDTH, 32: operand and result width in bits (8..64).
- N_OPS, 4: number of operand slots (2..8).
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset; clears all state.
- flush  in  1  synchronous clear of in-flight transactions, highest priority after reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block accepts bundle this cycle.
- in_ops  in  N_OPS*WIDTH  operand k at bits [k*WIDTH +: WIDTH].
- in_mask  in  N_OPS  bit k=1 includes operand k; 0 forces it to zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  masked sum mod 2^WIDTH.

## Operation
- Arithmetic: out_sum = Σ (in_mask[k] ? op_k : 0) mod 2^WIDTH; all carries beyond bit WIDTH-1 discarded, no overflow flag.
- Stage 1 (S1): masking + 3:2 CSA tree reduces N_OPS words to a (sum, carry<<1) pair, both WIDTH bits, registered with s1_valid. N_OPS=2 bypasses the tree (pair = the two masked operands).
- Stage 2 (S2): WIDTH-bit carry-propagate add of the pair, registered into out_sum with out_valid (= s2_valid).
- Stage advance: s2_adv = !out_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv. Ready path is combinational back to in_ready; no valid-to-ready dependence on in_valid.
- Transfer on in_valid & in_ready (input) and out_valid & out_ready (output). Stage data registers load only on advance with upstream valid; otherwise hold.
- While out_valid & !out_ready, out_sum and out_valid remain stable.
- Ordering strictly FIFO; no reordering, no drops except by flush/reset.
- flush=1: s1_valid, out_valid cleared next edge; in_ready still reported per rules but any bundle accepted that cycle is discarded. Data registers need not clear.
- Reset: s1_valid=0, out_valid=0, out_sum=0, internal pair registers=0; in_ready=1 once rst_n high.
- Reset asserted mid-operation: all in-flight results lost immediately (asynchronous); no partial output after release.

## Timing
- Latency: bundle accepted at edge t → out_valid=1 after edge t+2 (visible in cycle t+2) with no backpressure.
- Throughput: 1 bundle/cycle when out_ready held high.
- Capacity: 2 bundles in flight; with out_ready low, in_ready drops after the second unconsumed acceptance.
- Simultaneous output handshake and new input when full: both advance same cycle, no bubble.
- Critical path: S1 = ceil(log1.5(N_OPS/2)) CSA levels; S2 = one WIDTH-bit CPA.

## Structure
- sm3_pkg: SM3_WORD_W=32 default constant, csa3 function (sum = a^b^c, carry = majority<<1), sm3 IV constants used by the bench.
- Sub-module sm3_csa_tree (combinational, parameters WIDTH, N_OPS → sum/carry pair); sm3_madd_pipe holds masking, both pipeline registers and handshake.

## Test plan
- WIDTH=32, N_OPS=4, ops {0xFFFFFFFF,1,0,0}, mask 4'b1111 → out_sum=0x00000000, out_valid 2 cycles after acceptance.
- ops {0x7380166F,0x4914B2B9,0x172442D7,0xDEADBEEF}, mask 4'b0111 → out_sum=0xD3B90BFF; mask 4'b0000 → 0x00000000.
- Stream 3 bundles back-to-back, out_ready=0 for 5 cycles then 1 → in_ready low after 2 acceptances, first result held stable, results emerge in order, third accepted when first drains.
- Continuous in_valid/out_ready=1 for 100 random bundles, all N_OPS in {2,3,4,8} and WIDTH in {8,32} → one result per cycle matching model mod 2^WIDTH.
- flush asserted with 2 results in flight → out_valid=0 next cycle, next accepted bundle emerges correctly after 2 cycles.
- rst_n pulsed low mid-stream → out_valid=0, out_sum=0 immediately; in_ready=1 after release; no stale results.
